register: RTL and testbench



---
 rtl/pipeline_pkg.sv | 17 +
 rtl/register_enable_dff.sv | 43 ++++
 rtl/register.sv | 38 +++
 tb/tb_register.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
//   Shared widths and datatypes for the pipeline stage registers.
//   ADDR_W  : program-counter width (IF/ID PC register)
//   INSTR_W : instruction word width (IF/ID instruction register)
//   MAX_W   : widest register the generic storage element supports
// ----------------------------------------------------------------------------
package pipeline_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned MAX_W   = 128;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

endpackage : pipeline_pkg

// File: rtl/register_enable_dff.sv
// ----------------------------------------------------------------------------
// enable_dff
//   One-bit storage cell: asynchronous active-low clear to a per-bit reset
//   value, and an enable mux that either captures d_i or recirculates q.
//   clk_i     : rising-edge clock
//   rst_ni    : asynchronous reset, active low
//   rst_val_i : value forced onto q_o while rst_ni = 0 (tied constant)
//   en_i      : 1 = capture d_i at the rising edge, 0 = hold
//   d_i       : next value
//   q_o       : stored value
// ----------------------------------------------------------------------------
module enable_dff
   import pipeline_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rst_val_i,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (en_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= rst_val_i;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : enable_dff

// File: rtl/register.sv
// ----------------------------------------------------------------------------
// register
//   Generic N-bit pipeline stage register with write enable and asynchronous
//   active-low clear to RESET_VAL. Built from N independent enable_dff cells,
//   so bit i of data_out depends only on bit i of data_in.
//   clk      : rising-edge clock
//   reset    : asynchronous reset, active low
//   write_en : 1 = capture data_in at the rising edge, 0 = hold
//   data_in  : next value (N bits)
//   data_out : registered value (N bits), one clock after data_in
// ----------------------------------------------------------------------------
module register
   import pipeline_pkg::*;
#(
   parameter int unsigned     N         = ADDR_W,
   parameter logic [N-1:0]    RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         write_en,
   input  logic [N-1:0] data_in,
   output logic [N-1:0] data_out
);

   localparam logic [N-1:0] RST_V = RESET_VAL;

   for (genvar i = 0; i < int'(N); i++) begin : g_bit
      enable_dff u_cell (
         .clk_i     (clk),
         .rst_ni    (reset),
         .rst_val_i (RST_V[i]),
         .en_i      (write_en),
         .d_i       (data_in[i]),
         .q_o       (data_out[i])
      );
   end

endmodule : register

// File: tb/tb_register.sv
module tb_register;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst64, we64;
   logic [63:0] d64, o64;
   logic        rst32, we32;
   logic [31:0] d32, o32;
   logic        rst8, we8;
   logic [7:0]  d8, o8;

   register #(.N(64), .RESET_VAL(64'd0)) u64 (
      .clk(clk), .reset(rst64), .write_en(we64), .data_in(d64), .data_out(o64));
   register #(.N(32), .RESET_VAL(32'd0)) u32 (
      .clk(clk), .reset(rst32), .write_en(we32), .data_in(d32), .data_out(o32));
   register #(.N(8), .RESET_VAL(8'h3C)) u8 (
      .clk(clk), .reset(rst8), .write_en(we8), .data_in(d8), .data_out(o8));

   typedef struct {
      int          dut;
      logic [63:0] exp;
      string       name;
   } sb_t;

   sb_t sb[$];
   int  pushed = 0;
   int  popped = 0;
   int  total  = 0;
   int  bad    = 0;

   // Monitor: pops each expectation and compares against the selected DUT.
   initial begin
      sb_t         e;
      logic [63:0] act;
      forever begin
         wait (pushed != popped);
         e = sb.pop_front();
         case (e.dut)
            0:       act = o64;
            1:       act = {32'd0, o32};
            default: act = {56'd0, o8};
         endcase
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
         popped++;
      end
   end

   task automatic chk(input int dut, input logic [63:0] exp, input string nm);
      sb_t e;
      e.dut = dut; e.exp = exp; e.name = nm;
      sb.push_back(e);
      pushed++;
      wait (popped == pushed);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   logic [63:0] v1 [5] = '{64'd9999313, 64'd9999315, 64'd9999317, 64'd9999319, 64'd9999310};
   logic [31:0] v2 [5] = '{32'd1996, 32'd1998, 32'd1100, 32'd1102, 32'd1104};

   initial begin
      rst64 = 1'b0; we64 = 1'b0; d64 = '0;
      rst32 = 1'b0; we32 = 1'b0; d32 = '0;
      rst8  = 1'b0; we8  = 1'b1; d8  = 8'h55;
      @(negedge clk);
      chk(0, 64'd0,  "rst64");
      chk(1, 64'd0,  "rst32");
      chk(2, 64'h3C, "rst8");

      // Test 1: 64-bit back-to-back writes
      @(negedge clk);
      chk(0, 64'd0, "t1_in_reset");
      rst64 = 1'b1; we64 = 1'b1; d64 = v1[0];
      #1 chk(0, 64'd0, "t1_before_capture");
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         chk(0, v1[i-1], "t1_pipe");
         d64 = v1[i];
      end
      @(negedge clk);
      chk(0, v1[4], "t1_last");

      // Test 2: 32-bit back-to-back writes, then 10-cycle hold
      rst32 = 1'b1; we32 = 1'b1; d32 = v2[0];
      #1 chk(1, 64'd0, "t2_before_capture");
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         chk(1, {32'd0, v2[i-1]}, "t2_pipe");
         d32 = v2[i];
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk(1, 64'd1104, "t2_hold");
      end

      // Test 3: enable hold
      d32 = 32'hDEADBEEF;
      @(negedge clk);
      chk(1, 64'hDEADBEEF, "t3_load");
      we32 = 1'b0; d32 = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(1, 64'hDEADBEEF, "t3_hold");
      end
      we32 = 1'b1;
      #1 chk(1, 64'hDEADBEEF, "t3_before_edge");
      @(negedge clk);
      chk(1, 64'h12345678, "t3_resume");

      // Test 4: asynchronous reset between edges
      d32 = 32'd1104;
      @(negedge clk);
      chk(1, 64'd1104, "t4_preload");
      #2 rst32 = 1'b0;
      #1 chk(1, 64'd0, "t4_async_clear");
      d32 = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(1, 64'd0, "t4_reset_wins");
      end

      // Test 5: release between edges does not load
      d32 = 32'hA5;
      #2 rst32 = 1'b1;
      #1 chk(1, 64'd0, "t5_release_no_load");
      @(negedge clk);
      chk(1, 64'hA5, "t5_first_capture");

      // Test 6: non-zero reset value
      chk(2, 64'h3C, "t6_reset_val");
      rst8 = 1'b1; d8 = 8'hFF;
      #1 chk(2, 64'h3C, "t6_before_capture");
      @(negedge clk);
      chk(2, 64'hFF, "t6_write");
      #2 rst8 = 1'b0;
      #1 chk(2, 64'h3C, "t6_async_reassert");
      @(posedge clk);
      #1 chk(2, 64'h3C, "t6_edge_in_reset");

      for (int i = 0; i < 100 && pushed != popped; i++) #1;
      if (pushed != popped) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", pushed - popped);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_register
